// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue queue: queued operation record, FSM states
// and INP_VALID encodings.
package alu_issue_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_CMD_W = 3;

    localparam logic [1:0] INP_NONE = 2'b00;
    localparam logic [1:0] INP_A    = 2'b01;
    localparam logic [1:0] INP_B    = 2'b10;
    localparam logic [1:0] INP_AB   = 2'b11;

    typedef struct packed {
        logic                 mode;
        logic [ALU_CMD_W:0]   cmd;
        logic [ALU_WIDTH-1:0] opa;
        logic [ALU_WIDTH-1:0] opb;
        logic                 cin;
        logic                 split;
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BOTH,
        BEAT_A,
        BEAT_B
    } issue_state_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Source-side handshake plus ALU-side pins of the issue queue.
interface alu_issue_queue_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 3
);
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_mode;
    logic [CMD_WIDTH:0]   s_cmd;
    logic [WIDTH-1:0]     s_opa;
    logic [WIDTH-1:0]     s_opb;
    logic                 s_cin;
    logic                 s_split;
    logic                 hold;
    logic                 flush;
    logic [1:0]           INP_VALID;
    logic                 MODE;
    logic [CMD_WIDTH:0]   CMD;
    logic                 CE;
    logic [WIDTH-1:0]     OPA;
    logic [WIDTH-1:0]     OPB;
    logic                 CIN;
    logic [15:0]          issued_cnt;

    modport master (
        output s_valid, s_mode, s_cmd, s_opa, s_opb, s_cin, s_split, hold, flush,
        input  s_ready, INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, issued_cnt
    );

    modport slave (
        input  s_valid, s_mode, s_cmd, s_opa, s_opb, s_cin, s_split, hold, flush,
        output s_ready, INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, issued_cnt
    );
endinterface

// File: rtl/alu_issue_fifo.sv
// Small operation FIFO with wrap-bit pointers and a combinational head view
// so the issue FSM can load its output registers on the pop edge.
module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_op_t
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    T            mem_q [DEPTH];

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue FSM in front of the ALU: pops queued operations and drives them onto
// registered ALU pins, either as one combined beat or as OPA then OPB beats.
module alu_issue_queue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int CMD_WIDTH = ALU_CMD_W,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              RST,
    alu_issue_queue_if.slave  bus
);
    alu_op_t      push_op;
    alu_op_t      head;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         take;

    issue_state_t       state_q, state_d;
    logic [1:0]         inp_q, inp_d;
    logic               mode_q, mode_d;
    logic [CMD_WIDTH:0] cmd_q, cmd_d;
    logic               ce_q, ce_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               cin_q, cin_d;
    logic [WIDTH-1:0]   opb_pend_q, opb_pend_d;
    logic               reissue_q, reissue_d;
    logic [15:0]        cnt_q, cnt_d;

    assign bus.s_ready = !full && RST;
    assign push        = bus.s_valid && bus.s_ready && !bus.flush;
    assign push_op     = '{mode: bus.s_mode, cmd: bus.s_cmd, opa: bus.s_opa,
                           opb: bus.s_opb, cin: bus.s_cin, split: bus.s_split};

    alu_issue_fifo #(.DEPTH(DEPTH), .T(alu_op_t)) u_fifo (
        .clk     (clk),
        .rst_n_i (RST),
        .flush_i (bus.flush),
        .push_i  (push),
        .wdata_i (push_op),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d    = state_q;
        inp_d      = inp_q;
        mode_d     = mode_q;
        cmd_d      = cmd_q;
        ce_d       = 1'b0;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cin_d      = cin_q;
        opb_pend_d = opb_pend_q;
        reissue_d  = reissue_q;
        cnt_d      = cnt_q;
        take       = 1'b0;
        pop        = 1'b0;

        if (bus.flush) begin
            state_d   = IDLE;
            inp_d     = INP_NONE;
            mode_d    = 1'b0;
            cmd_d     = '0;
            opa_d     = '0;
            opb_d     = '0;
            cin_d     = 1'b0;
            reissue_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: take = !bus.hold && !empty;
                // A hold arriving here still moves to BEAT_B, but the OPB beat
                // is withheld (CE=0) and must be reissued once hold drops.
                BEAT_A: begin
                    state_d   = BEAT_B;
                    inp_d     = INP_B;
                    opb_d     = opb_pend_q;
                    ce_d      = !bus.hold;
                    reissue_d = bus.hold;
                end
                BOTH, BEAT_B: begin
                    if (bus.hold) begin
                        ce_d = 1'b0;
                    end else if (reissue_q) begin
                        ce_d      = 1'b1;
                        reissue_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (!empty) begin
                            take = 1'b1;
                        end else begin
                            state_d = IDLE;
                            inp_d   = INP_NONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (take) begin
                pop    = 1'b1;
                ce_d   = 1'b1;
                mode_d = head.mode;
                cmd_d  = head.cmd;
                opa_d  = head.opa;
                cin_d  = head.cin;
                if (head.split) begin
                    state_d    = BEAT_A;
                    inp_d      = INP_A;
                    opb_d      = '0;
                    opb_pend_d = head.opb;
                end else begin
                    state_d = BOTH;
                    inp_d   = INP_AB;
                    opb_d   = head.opb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            inp_q      <= INP_NONE;
            mode_q     <= 1'b0;
            cmd_q      <= '0;
            ce_q       <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            cin_q      <= 1'b0;
            opb_pend_q <= '0;
            reissue_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inp_q      <= inp_d;
            mode_q     <= mode_d;
            cmd_q      <= cmd_d;
            ce_q       <= ce_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cin_q      <= cin_d;
            opb_pend_q <= opb_pend_d;
            reissue_q  <= reissue_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.INP_VALID  = inp_q;
    assign bus.MODE       = mode_q;
    assign bus.CMD        = cmd_q;
    assign bus.CE         = ce_q;
    assign bus.OPA        = opa_q;
    assign bus.OPB        = opb_q;
    assign bus.CIN        = cin_q;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: per-cycle vector table plus hand-written
// sequences for full/hold, held split beat, flush and asynchronous reset.
module tb_alu_issue_queue;

    logic clk = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_queue_if #(.WIDTH(8), .CMD_WIDTH(3)) bus ();

    alu_issue_queue #(.WIDTH(8), .CMD_WIDTH(3), .DEPTH(4)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic        cin;
        logic        split;
        logic [1:0]  e_inp;
        logic        e_ce;
        logic        e_mode;
        logic [3:0]  e_cmd;
        logic [7:0]  e_opa;
        logic [7:0]  e_opb;
        logic        e_cin;
        logic        e_rdy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sp);
        bus.s_valid = v;
        bus.s_mode  = m;
        bus.s_cmd   = c;
        bus.s_opa   = a;
        bus.s_opb   = b;
        bus.s_cin   = ci;
        bus.s_split = sp;
    endtask

    task automatic pins(input string tag, input logic [1:0] inp, input logic ce,
                        input logic [7:0] opa, input logic [7:0] opb, input logic [15:0] cnt);
        chk({tag, ".inp"}, 32'(bus.INP_VALID), 32'(inp));
        chk({tag, ".ce"},  32'(bus.CE),        32'(ce));
        chk({tag, ".opa"}, 32'(bus.OPA),       32'(opa));
        chk({tag, ".opb"}, 32'(bus.OPB),       32'(opb));
        chk({tag, ".cnt"}, 32'(bus.issued_cnt), 32'(cnt));
        $display("%s: inp=%b ce=%b opa=%02h opb=%02h cnt=%0d", tag, bus.INP_VALID,
                 bus.CE, bus.OPA, bus.OPB, bus.issued_cnt);
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.hold  = 1'b0;
        bus.flush = 1'b0;

        //            v     mode  cmd   opa    opb    cin   split  inp   ce    mode  cmd   opa    opb    cin   rdy   cnt
        tbl[0]  = '{1'b1, 1'b1, 4'h0, 8'h12, 8'h34, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 4'h0, 8'h12, 8'h34, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 8'h12, 8'h34, 1'b0, 1'b1, 16'd1};
        tbl[3]  = '{1'b1, 1'b0, 4'h5, 8'hA5, 8'h5A, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 4'h0, 8'h12, 8'h34, 1'b0, 1'b1, 16'd1};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'h5, 8'hA5, 8'h00, 1'b1, 1'b1, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'h5, 8'hA5, 8'h5A, 1'b1, 1'b1, 16'd1};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h5, 8'hA5, 8'h5A, 1'b1, 1'b1, 16'd2};
        tbl[7]  = '{1'b1, 1'b1, 4'h2, 8'h11, 8'h22, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h5, 8'hA5, 8'h5A, 1'b1, 1'b1, 16'd2};
        tbl[8]  = '{1'b1, 1'b0, 4'h3, 8'h33, 8'h44, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 4'h2, 8'h11, 8'h22, 1'b0, 1'b1, 16'd2};
        tbl[9]  = '{1'b1, 1'b1, 4'h4, 8'h55, 8'h66, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'h3, 8'h33, 8'h00, 1'b1, 1'b1, 16'd3};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'h3, 8'h33, 8'h44, 1'b1, 1'b1, 16'd3};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 4'h4, 8'h55, 8'h66, 1'b0, 1'b1, 16'd4};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'h4, 8'h55, 8'h66, 1'b0, 1'b1, 16'd5};

        // Reset state while RST is low
        repeat (2) @(posedge clk);
        #1;
        pins("reset", 2'd0, 1'b0, 8'h00, 8'h00, 16'd0);
        chk("reset.mode",  32'(bus.MODE),    32'd0);
        chk("reset.cmd",   32'(bus.CMD),     32'd0);
        chk("reset.cin",   32'(bus.CIN),     32'd0);
        chk("reset.ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        RST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].mode, tbl[i].cmd, tbl[i].opa, tbl[i].opb, tbl[i].cin, tbl[i].split);
            step();
            chk($sformatf("vec%0d.inp", i),  32'(bus.INP_VALID),  32'(tbl[i].e_inp));
            chk($sformatf("vec%0d.ce", i),   32'(bus.CE),         32'(tbl[i].e_ce));
            chk($sformatf("vec%0d.mode", i), 32'(bus.MODE),       32'(tbl[i].e_mode));
            chk($sformatf("vec%0d.cmd", i),  32'(bus.CMD),        32'(tbl[i].e_cmd));
            chk($sformatf("vec%0d.opa", i),  32'(bus.OPA),        32'(tbl[i].e_opa));
            chk($sformatf("vec%0d.opb", i),  32'(bus.OPB),        32'(tbl[i].e_opb));
            chk($sformatf("vec%0d.cin", i),  32'(bus.CIN),        32'(tbl[i].e_cin));
            chk($sformatf("vec%0d.rdy", i),  32'(bus.s_ready),    32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.cnt", i),  32'(bus.issued_cnt), 32'(tbl[i].e_cnt));
            $display("vec%0d: inp=%b ce=%b opa=%02h opb=%02h cnt=%0d", i, bus.INP_VALID,
                     bus.CE, bus.OPA, bus.OPB, bus.issued_cnt);
        end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Fill the queue under hold, then drain as contiguous BOTH beats
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 4'h0, 8'(8'h80 + i), 8'(8'h90 + i), 1'b0, 1'b0);
            chk($sformatf("fill%0d.rdy", i), 32'(bus.s_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("full.rdy", 32'(bus.s_ready), 32'd0);
        pins("full.held", 2'd0, 1'b0, 8'h55, 8'h66, 16'd5);
        step();
        pins("full.held2", 2'd0, 1'b0, 8'h55, 8'h66, 16'd5);
        bus.hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            pins($sformatf("drain%0d", i), 2'd3, 1'b1, 8'(8'h80 + i), 8'(8'h90 + i), 16'(5 + i));
        end
        step();
        pins("drain.end", 2'd0, 1'b0, 8'h83, 8'h93, 16'd9);

        // Hold raised between BEAT_A and BEAT_B for three cycles
        drive(1'b1, 1'b1, 4'h7, 8'hC1, 8'hC2, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        pins("hb.beatA", 2'd1, 1'b1, 8'hC1, 8'h00, 16'd9);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            pins($sformatf("hb.held%0d", i), 2'd2, 1'b0, 8'hC1, 8'hC2, 16'd9);
        end
        bus.hold = 1'b0;
        step();
        pins("hb.reissue", 2'd2, 1'b1, 8'hC1, 8'hC2, 16'd9);
        step();
        pins("hb.done", 2'd0, 1'b0, 8'hC1, 8'hC2, 16'd10);

        // Flush during BEAT_A with three entries still queued
        bus.hold = 1'b1;
        drive(1'b1, 1'b1, 4'h6, 8'hD1, 8'hD2, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'h1, 8'(8'hE1 + i), 8'(8'hF1 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("fl.full", 32'(bus.s_ready), 32'd0);
        bus.hold = 1'b0;
        step();
        pins("fl.beatA", 2'd1, 1'b1, 8'hD1, 8'h00, 16'd10);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        pins("fl.flushed", 2'd0, 1'b0, 8'h00, 8'h00, 16'd10);
        chk("fl.mode", 32'(bus.MODE),    32'd0);
        chk("fl.cmd",  32'(bus.CMD),     32'd0);
        chk("fl.cin",  32'(bus.CIN),     32'd0);
        chk("fl.rdy",  32'(bus.s_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            pins($sformatf("fl.after%0d", i), 2'd0, 1'b0, 8'h00, 8'h00, 16'd10);
        end

        // Asynchronous reset in the middle of a split operation
        drive(1'b1, 1'b1, 4'h2, 8'hB1, 8'hB2, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        pins("ar.beatA", 2'd1, 1'b1, 8'hB1, 8'h00, 16'd10);
        #2;
        RST = 1'b0;
        #1;
        pins("ar.async", 2'd0, 1'b0, 8'h00, 8'h00, 16'd0);
        chk("ar.mode", 32'(bus.MODE),    32'd0);
        chk("ar.cin",  32'(bus.CIN),     32'd0);
        chk("ar.rdy",  32'(bus.s_ready), 32'd0);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            pins($sformatf("ar.idle%0d", i), 2'd0, 1'b0, 8'h00, 8'h00, 16'd0);
            chk($sformatf("ar.idle%0d.rdy", i), 32'(bus.s_ready), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
